// File: rtl/flit_sink_monitor.sv
// flit_sink_monitor: receive-side framing checker for a mux output port.
// It tracks HEAD / DATA* / TAIL packet framing and counts packets, flits
// and the payload bit toggles between consecutive flits of a packet.
// Error flags are sticky and keep the first error code seen.
module flit_sink_monitor #(
  parameter int PAYW       = 64,
  parameter int TYPEW      = 3,
  parameter int VCHW       = 1,
  parameter int MAXLEN     = 1024,
  parameter int T_NONE     = 0,
  parameter int T_HEAD     = 1,
  parameter int T_TAIL     = 2,
  parameter int T_HEADTAIL = 3,
  parameter int T_DATA     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TYPEW+PAYW-1:0] idata,
  input  logic                  ivalid,
  input  logic [VCHW-1:0]       ivch,
  input  logic                  clr,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           flit_cnt,
  output logic [31:0]           toggle_cnt,
  output logic [15:0]           last_len,
  output logic                  pkt_done,
  output logic                  busy,
  output logic                  err,
  output logic [2:0]            err_code
);

  localparam int CNTW = $clog2(PAYW + 1);
  localparam logic [TYPEW-1:0] TY_NONE     = TYPEW'(T_NONE);
  localparam logic [TYPEW-1:0] TY_HEAD     = TYPEW'(T_HEAD);
  localparam logic [TYPEW-1:0] TY_TAIL     = TYPEW'(T_TAIL);
  localparam logic [TYPEW-1:0] TY_HEADTAIL = TYPEW'(T_HEADTAIL);
  localparam logic [TYPEW-1:0] TY_DATA     = TYPEW'(T_DATA);
  localparam logic [15:0]      MAXLEN_L    = 16'(MAXLEN);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BODY = 1'b1} state_t;

  // Number of set bits in a payload word.
  function automatic logic [CNTW-1:0] popcount(input logic [PAYW-1:0] v);
    logic [CNTW-1:0] c;
    c = '0;
    for (int i = 0; i < PAYW; i++) begin
      c = c + CNTW'(v[i]);
    end
    return c;
  endfunction

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  state_t            state_r, state_n;
  logic [PAYW-1:0]   prev_r, prev_n;
  logic [15:0]       len_r, len_n;
  logic [VCHW-1:0]   vch_r, vch_n;
  logic              ovl_r, ovl_n;
  logic [31:0]       pkt_cnt_r, pkt_cnt_n;
  logic [31:0]       flit_cnt_r, flit_cnt_n;
  logic [31:0]       toggle_cnt_r, toggle_cnt_n;
  logic [15:0]       last_len_r, last_len_n;
  logic              pkt_done_r;
  logic              err_r, err_n;
  logic [2:0]        err_code_r, err_code_n;

  logic [TYPEW-1:0]  typ_s;
  logic [PAYW-1:0]   pay_s;
  logic [CNTW-1:0]   hd_s;
  logic              done_s;
  logic [15:0]       done_len_s;
  logic [31:0]       tog_inc_s;
  logic [2:0]        ecode_s;

  assign typ_s = idata[TYPEW+PAYW-1:PAYW];
  assign pay_s = idata[PAYW-1:0];
  assign hd_s  = popcount(pay_s ^ prev_r);

  // Framing FSM: next state, packet registers and the error raised by this flit.
  always_comb begin
    state_n    = state_r;
    prev_n     = prev_r;
    len_n      = len_r;
    vch_n      = vch_r;
    ovl_n      = ovl_r;
    done_s     = 1'b0;
    done_len_s = 16'd0;
    tog_inc_s  = 32'd0;
    ecode_s    = 3'd0;
    if (ivalid) begin
      case (state_r)
        S_IDLE: begin
          case (typ_s)
            TY_HEAD: begin
              state_n = S_BODY;
              len_n   = 16'd1;
              vch_n   = ivch;
              prev_n  = pay_s;
              ovl_n   = 1'b0;
            end
            TY_HEADTAIL: begin
              len_n      = 16'd1;
              done_s     = 1'b1;
              done_len_s = 16'd1;
            end
            TY_DATA, TY_TAIL: ecode_s = 3'd1;
            TY_NONE:          ecode_s = 3'd4;
            default:          ecode_s = 3'd4;
          endcase
        end
        S_BODY: begin
          case (typ_s)
            TY_DATA, TY_TAIL: begin
              if (len_r >= MAXLEN_L) begin
                len_n = MAXLEN_L;
                if (!ovl_r) begin
                  ecode_s = 3'd5;
                  ovl_n   = 1'b1;
                end else begin
                  ovl_n   = 1'b1;
                end
              end else begin
                len_n = len_r + 16'd1;
              end
              // A channel change outranks an overlength on the same flit.
              if (ivch != vch_r) begin
                ecode_s = 3'd3;
              end else begin
                ecode_s = ecode_s;
              end
              tog_inc_s = 32'(hd_s);
              prev_n    = pay_s;
              if (typ_s == TY_TAIL) begin
                state_n    = S_IDLE;
                done_s     = 1'b1;
                done_len_s = len_n;
              end else begin
                state_n    = S_BODY;
              end
            end
            TY_HEAD: begin
              // Abandon the open packet and restart from this flit.
              ecode_s = 3'd2;
              state_n = S_BODY;
              len_n   = 16'd1;
              vch_n   = ivch;
              prev_n  = pay_s;
              ovl_n   = 1'b0;
            end
            TY_HEADTAIL: begin
              ecode_s    = 3'd2;
              state_n    = S_IDLE;
              len_n      = 16'd1;
              done_s     = 1'b1;
              done_len_s = 16'd1;
            end
            TY_NONE: ecode_s = 3'd4;
            default: ecode_s = 3'd4;
          endcase
        end
        default: state_n = S_IDLE;
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Counters and sticky error: clr zeroes the base, this cycle's flit adds on top.
  always_comb begin
    pkt_cnt_n    = clr ? 32'd0 : pkt_cnt_r;
    flit_cnt_n   = clr ? 32'd0 : flit_cnt_r;
    toggle_cnt_n = clr ? 32'd0 : toggle_cnt_r;
    last_len_n   = clr ? 16'd0 : last_len_r;
    err_n        = clr ? 1'b0  : err_r;
    err_code_n   = clr ? 3'd0  : err_code_r;
    pkt_cnt_n    = sat_add(pkt_cnt_n, {31'd0, done_s});
    flit_cnt_n   = sat_add(flit_cnt_n, {31'd0, ivalid});
    toggle_cnt_n = sat_add(toggle_cnt_n, tog_inc_s);
    if (done_s) begin
      last_len_n = done_len_s;
    end else begin
      last_len_n = last_len_n;
    end
    if ((ecode_s != 3'd0) && !err_n) begin
      err_n      = 1'b1;
      err_code_n = ecode_s;
    end else begin
      err_code_n = err_code_n;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      prev_r       <= '0;
      len_r        <= 16'd0;
      vch_r        <= '0;
      ovl_r        <= 1'b0;
      pkt_cnt_r    <= 32'd0;
      flit_cnt_r   <= 32'd0;
      toggle_cnt_r <= 32'd0;
      last_len_r   <= 16'd0;
      pkt_done_r   <= 1'b0;
      err_r        <= 1'b0;
      err_code_r   <= 3'd0;
    end else begin
      state_r      <= state_n;
      prev_r       <= prev_n;
      len_r        <= len_n;
      vch_r        <= vch_n;
      ovl_r        <= ovl_n;
      pkt_cnt_r    <= pkt_cnt_n;
      flit_cnt_r   <= flit_cnt_n;
      toggle_cnt_r <= toggle_cnt_n;
      last_len_r   <= last_len_n;
      pkt_done_r   <= done_s;
      err_r        <= err_n;
      err_code_r   <= err_code_n;
    end
  end

  assign pkt_cnt    = pkt_cnt_r;
  assign flit_cnt   = flit_cnt_r;
  assign toggle_cnt = toggle_cnt_r;
  assign last_len   = last_len_r;
  assign pkt_done   = pkt_done_r;
  assign busy       = (state_r == S_BODY);
  assign err        = err_r;
  assign err_code   = err_code_r;

endmodule

// File: tb/tb_flit_sink_monitor.sv
// Directed self-checking bench for flit_sink_monitor.
module tb_flit_sink_monitor;

  localparam logic [2:0] T_NONE     = 3'd0;
  localparam logic [2:0] T_HEAD     = 3'd1;
  localparam logic [2:0] T_TAIL     = 3'd2;
  localparam logic [2:0] T_HEADTAIL = 3'd3;
  localparam logic [2:0] T_DATA     = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic [66:0] idata;
  logic        ivalid;
  logic [0:0]  ivch;
  logic        clr;
  logic [31:0] pkt_cnt, flit_cnt, toggle_cnt;
  logic [15:0] last_len;
  logic        pkt_done, busy, err;
  logic [2:0]  err_code;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  int pulse_base;
  int busy_drops;

  flit_sink_monitor dut (
    .clk(clk), .rst(rst), .idata(idata), .ivalid(ivalid), .ivch(ivch), .clr(clr),
    .pkt_cnt(pkt_cnt), .flit_cnt(flit_cnt), .toggle_cnt(toggle_cnt),
    .last_len(last_len), .pkt_done(pkt_done), .busy(busy), .err(err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Count pkt_done pulses mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (pkt_done === 1'b1) pulses <= pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int i);
    logic [7:0] b;
    case (i % 8)
      0: b = 8'h03;
      1: b = 8'h0F;
      2: b = 8'h3F;
      3: b = 8'hFF;
      4: b = 8'hFC;
      5: b = 8'hF0;
      6: b = 8'hC0;
      default: b = 8'h00;
    endcase
    return {8{b}};
  endfunction

  task automatic send(input logic [2:0] t, input logic [63:0] p, input logic v);
    idata = {t, p};
    ivch = v;
    ivalid = 1'b1;
    @(posedge clk);
    #1;
    ivalid = 1'b0;
    idata = '0;
    ivch = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // HEAD with payload 0, 20 DATA and a TAIL, with optional bubbles after each flit.
  task automatic nominal_pkt(input int bubbles);
    send(T_HEAD, 64'd0, 1'b0);
    for (int k = 0; k < bubbles; k++) begin
      if (busy !== 1'b1) busy_drops++;
      idle(1);
    end
    for (int i = 0; i < 21; i++) begin
      send((i == 20) ? T_TAIL : T_DATA, pat(i), 1'b0);
      for (int k = 0; k < bubbles; k++) begin
        if (i != 20 && busy !== 1'b1) busy_drops++;
        idle(1);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ivalid = 1'b0; idata = '0; ivch = 1'b0;
    idle(2);
    check("rst_pkt_cnt", pkt_cnt, 32'd0);
    check("rst_flit_cnt", flit_cnt, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Nominal packet
    pulse_base = pulses;
    send(T_HEAD, 64'd0, 1'b0);
    check("head_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 21; i++) send((i == 20) ? T_TAIL : T_DATA, pat(i), 1'b0);
    check("nom_done", {31'd0, pkt_done}, 32'd1);
    check("nom_busy", {31'd0, busy}, 32'd0);
    idle(1);
    check("nom_done_fall", {31'd0, pkt_done}, 32'd0);
    check("nom_pkt", pkt_cnt, 32'd1);
    check("nom_flit", flit_cnt, 32'd22);
    check("nom_len", {16'd0, last_len}, 32'd22);
    check("nom_tog", toggle_cnt, 32'd336);
    check("nom_err", {31'd0, err}, 32'd0);
    check("nom_pulses", 32'(pulses - pulse_base), 32'd1);

    // Same packet with 7 bubbles after every flit
    do_reset();
    busy_drops = 0;
    nominal_pkt(7);
    check("bub_pkt", pkt_cnt, 32'd1);
    check("bub_flit", flit_cnt, 32'd22);
    check("bub_len", {16'd0, last_len}, 32'd22);
    check("bub_tog", toggle_cnt, 32'd336);
    check("bub_busy_held", 32'(busy_drops), 32'd0);

    // Ten packets back to back
    do_reset();
    pulse_base = pulses;
    for (int p = 0; p < 10; p++) nominal_pkt(0);
    idle(1);
    check("ten_pkt", pkt_cnt, 32'd10);
    check("ten_flit", flit_cnt, 32'd220);
    check("ten_tog", toggle_cnt, 32'd3360);
    check("ten_pulses", 32'(pulses - pulse_base), 32'd10);
    check("ten_err", {31'd0, err}, 32'd0);

    // Asynchronous reset in the middle of a packet
    send(T_HEAD, 64'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(T_DATA, pat(i), 1'b0);
    rst = 1'b1;
    #1;
    check("arst_pkt", pkt_cnt, 32'd0);
    check("arst_flit", flit_cnt, 32'd0);
    check("arst_tog", toggle_cnt, 32'd0);
    check("arst_len", {16'd0, last_len}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, pkt_done}, 32'd0);
    check("arst_err", {29'd0, err, err_code[1:0]} | {29'd0, err_code}, 32'd0);
    rst = 1'b0;
    send(T_DATA, pat(3), 1'b0);
    check("orphan_err", {31'd0, err}, 32'd1);
    check("orphan_code", {29'd0, err_code}, 32'd1);
    check("orphan_flit", flit_cnt, 32'd1);
    check("orphan_busy", {31'd0, busy}, 32'd0);

    // Channel change, then nested HEAD, then completion
    do_reset();
    send(T_HEAD, 64'd0, 1'b0);
    send(T_DATA, pat(0), 1'b1);
    check("vch_code", {29'd0, err_code}, 32'd3);
    send(T_HEAD, 64'd0, 1'b0);
    check("nest_code", {29'd0, err_code}, 32'd3);
    check("nest_pkt", pkt_cnt, 32'd0);
    check("nest_busy", {31'd0, busy}, 32'd1);
    send(T_TAIL, pat(0), 1'b0);
    check("nest_done_pkt", pkt_cnt, 32'd1);
    check("nest_len", {16'd0, last_len}, 32'd2);
    check("nest_tog", toggle_cnt, 32'd32);
    check("nest_flit", flit_cnt, 32'd4);

    // clr in the middle of a packet
    do_reset();
    send(T_HEAD, 64'd0, 1'b0);
    for (int i = 0; i < 5; i++) send(T_DATA, pat(i), 1'b0);
    send(T_NONE, 64'd0, 1'b0);
    check("pre_clr_err", {29'd0, err_code}, 32'd4);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_flit", flit_cnt, 32'd0);
    check("clr_err", {31'd0, err}, 32'd0);
    check("clr_code", {29'd0, err_code}, 32'd0);
    check("clr_busy", {31'd0, busy}, 32'd1);
    send(T_TAIL, pat(5), 1'b0);
    check("clr_pkt", pkt_cnt, 32'd1);
    check("clr_len", {16'd0, last_len}, 32'd7);
    check("clr_flit_after", flit_cnt, 32'd1);
    check("clr_tog", toggle_cnt, 32'd16);

    // clr coinciding with a flit: increments land on zeroed counters
    clr = 1'b1;
    send(T_HEADTAIL, 64'd0, 1'b0);
    clr = 1'b0;
    check("clr_same_flit", flit_cnt, 32'd1);
    check("clr_same_pkt", pkt_cnt, 32'd1);
    check("clr_same_len", {16'd0, last_len}, 32'd1);

    // Back-to-back HEADTAIL flits give consecutive pulses
    do_reset();
    pulse_base = pulses;
    send(T_HEADTAIL, 64'd0, 1'b0);
    check("ht1_done", {31'd0, pkt_done}, 32'd1);
    send(T_HEADTAIL, 64'd0, 1'b0);
    check("ht2_done", {31'd0, pkt_done}, 32'd1);
    check("ht2_pkt", pkt_cnt, 32'd2);
    idle(1);
    check("ht_pulses", 32'(pulses - pulse_base), 32'd2);
    check("ht_busy", {31'd0, busy}, 32'd0);

    // Bad type inside a packet: no toggle update, stays in BODY
    do_reset();
    send(T_HEAD, 64'd0, 1'b0);
    send(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("bad_code", {29'd0, err_code}, 32'd4);
    check("bad_busy", {31'd0, busy}, 32'd1);
    check("bad_tog", toggle_cnt, 32'd0);
    send(T_TAIL, pat(0), 1'b0);
    check("bad_tail_tog", toggle_cnt, 32'd16);
    check("bad_tail_pkt", pkt_cnt, 32'd1);

    // Overlength: exactly 1024 flits is legal, the 1025th flags code 5
    do_reset();
    send(T_HEAD, 64'd0, 1'b0);
    for (int i = 0; i < 1023; i++) send(T_DATA, pat(i), 1'b0);
    check("max_ok_err", {31'd0, err}, 32'd0);
    send(T_DATA, pat(1023), 1'b0);
    check("ovl_code", {29'd0, err_code}, 32'd5);
    send(T_TAIL, pat(1024), 1'b0);
    check("ovl_len", {16'd0, last_len}, 32'd1024);
    check("ovl_flit", flit_cnt, 32'd1026);
    check("ovl_pkt", pkt_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
